// File: rtl/probe_tracker.sv
// probe_tracker
//   Tracks one probe per MSHR between the broadcast filter and the client.
//   A filter response either needs a probe (allocOH=1) or completes straight
//   away (allocOH=0). Probes go out on the B channel under round-robin
//   arbitration. Returning ProbeAcks are matched by address, and completions
//   are reported to the MSHRs as one-cycle pulses.
//
//   Optional build macro: PROBE_TRACKER_TIMEOUT_EN
//     When it is defined, every entry counts its cycles in WAIT. When the count
//     reaches TIMEOUT, the entry flags io_error and returns to ISSUE so the
//     probe is sent again. When it is undefined, WAIT lasts until a matching ack.
//
// Ports
//   clock, reset          : single clock; synchronous active-high reset
//   io_request_*          : filter response in (ready = target entry is IDLE)
//   io_probe_*            : B-channel probe out (param 2 = toN, 1 = toB)
//   io_ack_*              : C-channel ProbeAck in (always ready)
//   io_done_*             : registered one-cycle completion pulse + MSHR index
//   io_busy               : some entry is not IDLE
//   io_error              : sticky protocol error (unmatched/duplicate ack, timeout)
module probe_tracker #(
  parameter int MSHRS   = 4,
  parameter int MSHR_W  = 2,
  parameter int ADDR_W  = 33,
  parameter int TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  output logic              io_request_ready,
  input  logic              io_request_valid,
  input  logic [MSHR_W-1:0] io_request_bits_mshr,
  input  logic [ADDR_W-1:0] io_request_bits_address,
  input  logic              io_request_bits_allocOH,
  input  logic              io_request_bits_needT,
  input  logic              io_probe_ready,
  output logic              io_probe_valid,
  output logic [ADDR_W-1:0] io_probe_bits_address,
  output logic [1:0]        io_probe_bits_param,
  input  logic              io_ack_valid,
  output logic              io_ack_ready,
  input  logic [ADDR_W-1:0] io_ack_bits_address,
  output logic              io_done_valid,
  output logic [MSHR_W-1:0] io_done_bits_mshr,
  output logic              io_busy,
  output logic              io_error
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  // Per-entry storage
  state_t            state_reg [MSHRS];
  logic [ADDR_W-1:0] addr_reg  [MSHRS];
  logic [MSHRS-1:0]  need_t_reg;

  // Arbiter state
  logic [MSHR_W-1:0] rr_ptr_reg;
  logic              lock_reg;
  logic [MSHR_W-1:0] lock_idx_reg;

  // Registered outputs
  logic              done_valid_reg;
  logic [MSHR_W-1:0] done_mshr_reg;
  logic              error_reg;

  // ------------------------------------------------------------------
  // Request side
  // ------------------------------------------------------------------
  logic req_fire;

  assign io_request_ready = (state_reg[io_request_bits_mshr] == ST_IDLE);
  assign req_fire         = io_request_valid && io_request_ready;

  // ------------------------------------------------------------------
  // Probe arbitration: round-robin from rr_ptr_reg. Once a probe has been
  // offered without being accepted, the grant is frozen so the B channel
  // sees a stable address and param until the handshake completes.
  // ------------------------------------------------------------------
  logic [MSHRS-1:0]  issue_vec;
  logic              rr_found;
  logic [MSHR_W-1:0] rr_idx;
  logic              grant_valid;
  logic [MSHR_W-1:0] grant_idx;
  logic [MSHR_W-1:0] grant_next_ptr;
  logic              probe_fire;

  always_comb begin
    for (int i = 0; i < MSHRS; i++) begin
      issue_vec[i] = (state_reg[i] == ST_ISSUE);
    end
  end

  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int k = 0; k < MSHRS; k++) begin
      if (!rr_found && issue_vec[(int'(rr_ptr_reg) + k) % MSHRS]) begin
        rr_found = 1'b1;
        rr_idx   = MSHR_W'((int'(rr_ptr_reg) + k) % MSHRS);
      end
    end
  end

  assign grant_valid    = lock_reg || rr_found;
  assign grant_idx      = lock_reg ? lock_idx_reg : rr_idx;
  assign grant_next_ptr = (grant_idx == MSHR_W'(MSHRS - 1)) ? '0 : grant_idx + 1'b1;
  assign probe_fire     = grant_valid && io_probe_ready;

  assign io_probe_valid        = grant_valid;
  assign io_probe_bits_address = addr_reg[grant_idx];
  assign io_probe_bits_param   = need_t_reg[grant_idx] ? 2'd2 : 2'd1;

  // ------------------------------------------------------------------
  // Ack matching: only WAIT entries can match. A duplicate match is an
  // error, but the lowest index still takes the ack.
  // ------------------------------------------------------------------
  logic              ack_any;
  logic              ack_multi;
  logic [MSHR_W-1:0] ack_idx;
  logic              ack_error;

  assign io_ack_ready = 1'b1;

  always_comb begin
    ack_any   = 1'b0;
    ack_multi = 1'b0;
    ack_idx   = '0;
    for (int i = 0; i < MSHRS; i++) begin
      if (io_ack_valid && state_reg[i] == ST_WAIT && addr_reg[i] == io_ack_bits_address) begin
        if (ack_any) begin
          ack_multi = 1'b1;
        end else begin
          ack_any = 1'b1;
          ack_idx = MSHR_W'(i);
        end
      end
    end
  end

  assign ack_error = io_ack_valid && (!ack_any || ack_multi);

  // ------------------------------------------------------------------
  // Completion select: lowest-index DONE entry
  // ------------------------------------------------------------------
  logic              done_found;
  logic [MSHR_W-1:0] done_idx;

  always_comb begin
    done_found = 1'b0;
    done_idx   = '0;
    for (int i = 0; i < MSHRS; i++) begin
      if (!done_found && state_reg[i] == ST_DONE) begin
        done_found = 1'b1;
        done_idx   = MSHR_W'(i);
      end
    end
  end

  // ------------------------------------------------------------------
  // WAIT timeout
  // ------------------------------------------------------------------
  logic [MSHRS-1:0] timeout_vec;
  logic             timeout_any;

`ifdef PROBE_TRACKER_TIMEOUT_EN
  logic [7:0] wait_cnt_reg [MSHRS];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < MSHRS; i++) begin
        wait_cnt_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < MSHRS; i++) begin
        if (probe_fire && grant_idx == MSHR_W'(i)) begin
          wait_cnt_reg[i] <= '0;
        end else if (state_reg[i] == ST_WAIT) begin
          wait_cnt_reg[i] <= wait_cnt_reg[i] + 8'd1;
        end
      end
    end
  end

  // A matching ack in the same cycle wins over the timeout.
  always_comb begin
    for (int i = 0; i < MSHRS; i++) begin
      timeout_vec[i] = (state_reg[i] == ST_WAIT) && (wait_cnt_reg[i] == TIMEOUT_CNT) &&
                       !(ack_any && ack_idx == MSHR_W'(i));
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT_CNT;
  assign timeout_vec    = '0;
`endif

  assign timeout_any = |timeout_vec;

  // ------------------------------------------------------------------
  // Entry state, arbiter and output registers. Request, probe fire, ack
  // and completion always target entries in different states, so at most
  // one of them applies to any entry in a given cycle.
  // ------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < MSHRS; i++) begin
        state_reg[i] <= ST_IDLE;
        addr_reg[i]  <= '0;
      end
      need_t_reg     <= '0;
      rr_ptr_reg     <= '0;
      lock_reg       <= 1'b0;
      lock_idx_reg   <= '0;
      done_valid_reg <= 1'b0;
      done_mshr_reg  <= '0;
      error_reg      <= 1'b0;
    end else begin
      for (int i = 0; i < MSHRS; i++) begin
        if (req_fire && io_request_bits_mshr == MSHR_W'(i)) begin
          addr_reg[i]   <= io_request_bits_address;
          need_t_reg[i] <= io_request_bits_needT;
          state_reg[i]  <= io_request_bits_allocOH ? ST_ISSUE : ST_DONE;
        end else if (probe_fire && grant_idx == MSHR_W'(i)) begin
          state_reg[i] <= ST_WAIT;
        end else if (ack_any && ack_idx == MSHR_W'(i)) begin
          state_reg[i] <= ST_DONE;
        end else if (timeout_vec[i]) begin
          state_reg[i] <= ST_ISSUE;
        end else if (done_found && done_idx == MSHR_W'(i)) begin
          state_reg[i] <= ST_IDLE;
        end
      end

      if (probe_fire) begin
        lock_reg   <= 1'b0;
        rr_ptr_reg <= grant_next_ptr;
      end else if (grant_valid) begin
        lock_reg     <= 1'b1;
        lock_idx_reg <= grant_idx;
      end

      done_valid_reg <= done_found;
      if (done_found) begin
        done_mshr_reg <= done_idx;
      end

      if (ack_error || timeout_any) begin
        error_reg <= 1'b1;
      end
    end
  end

  assign io_done_valid     = done_valid_reg;
  assign io_done_bits_mshr = done_mshr_reg;
  assign io_error          = error_reg;

  always_comb begin
    io_busy = 1'b0;
    for (int i = 0; i < MSHRS; i++) begin
      if (state_reg[i] != ST_IDLE) begin
        io_busy = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_probe_tracker.sv
// Directed testbench for probe_tracker. Inputs change 1 time unit after each
// rising edge, and outputs are sampled on the falling edge of the same cycle.
// Building with PROBE_TRACKER_TIMEOUT_EN also runs the WAIT timeout scenario
// with TIMEOUT=4.
module tb_probe_tracker;

`ifdef PROBE_TRACKER_TIMEOUT_EN
  localparam int TB_TIMEOUT = 4;
`else
  localparam int TB_TIMEOUT = 255;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        io_request_ready;
  logic        io_request_valid;
  logic [1:0]  io_request_bits_mshr;
  logic [32:0] io_request_bits_address;
  logic        io_request_bits_allocOH;
  logic        io_request_bits_needT;
  logic        io_probe_ready;
  logic        io_probe_valid;
  logic [32:0] io_probe_bits_address;
  logic [1:0]  io_probe_bits_param;
  logic        io_ack_valid;
  logic        io_ack_ready;
  logic [32:0] io_ack_bits_address;
  logic        io_done_valid;
  logic [1:0]  io_done_bits_mshr;
  logic        io_busy;
  logic        io_error;

  int n_checks = 0;
  int n_errors = 0;

  probe_tracker #(
    .MSHRS(4), .MSHR_W(2), .ADDR_W(33), .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .clock                   (clock),
    .reset                   (reset),
    .io_request_ready        (io_request_ready),
    .io_request_valid        (io_request_valid),
    .io_request_bits_mshr    (io_request_bits_mshr),
    .io_request_bits_address (io_request_bits_address),
    .io_request_bits_allocOH (io_request_bits_allocOH),
    .io_request_bits_needT   (io_request_bits_needT),
    .io_probe_ready          (io_probe_ready),
    .io_probe_valid          (io_probe_valid),
    .io_probe_bits_address   (io_probe_bits_address),
    .io_probe_bits_param     (io_probe_bits_param),
    .io_ack_valid            (io_ack_valid),
    .io_ack_ready            (io_ack_ready),
    .io_ack_bits_address     (io_ack_bits_address),
    .io_done_valid           (io_done_valid),
    .io_done_bits_mshr       (io_done_bits_mshr),
    .io_busy                 (io_busy),
    .io_error                (io_error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic req(input logic v, input logic [1:0] m, input logic [32:0] a,
                     input logic alloc, input logic nt);
    io_request_valid        = v;
    io_request_bits_mshr    = m;
    io_request_bits_address = a;
    io_request_bits_allocOH = alloc;
    io_request_bits_needT   = nt;
  endtask

  task automatic ack(input logic v, input logic [32:0] a);
    io_ack_valid        = v;
    io_ack_bits_address = a;
  endtask

  task automatic chk_probe(input string tag, input logic [32:0] a, input logic [1:0] p);
    chk({tag, "_valid"}, 64'(io_probe_valid), 64'd1);
    chk({tag, "_addr"}, 64'(io_probe_bits_address), 64'(a));
    chk({tag, "_param"}, 64'(io_probe_bits_param), 64'(p));
    $display("probe %s: addr=0x%0h param=%0d", tag, io_probe_bits_address, io_probe_bits_param);
  endtask

  task automatic chk_done(input string tag, input logic [1:0] m);
    chk({tag, "_valid"}, 64'(io_done_valid), 64'd1);
    chk({tag, "_mshr"}, 64'(io_done_bits_mshr), 64'(m));
    $display("done %s: mshr=%0d", tag, io_done_bits_mshr);
  endtask

  initial begin
    logic exp_err_pre;

    reset = 1'b1;
    req(1'b0, 2'd0, 33'h0, 1'b0, 1'b0);
    ack(1'b0, 33'h0);
    io_probe_ready = 1'b0;

    // Reset held for two cycles
    next_cycle();
    next_cycle();
    reset = 1'b0;
    sample();
    for (int m = 0; m < 4; m++) begin
      io_request_bits_mshr = 2'(m);
      #1;
      chk("reset_ready", 64'(io_request_ready), 64'd1);
    end
    chk("reset_probe_valid", 64'(io_probe_valid), 64'd0);
    chk("reset_done_valid", 64'(io_done_valid), 64'd0);
    chk("reset_done_mshr", 64'(io_done_bits_mshr), 64'd0);
    chk("reset_busy", 64'(io_busy), 64'd0);
    chk("reset_error", 64'(io_error), 64'd0);
    chk("ack_ready", 64'(io_ack_ready), 64'd1);
    $display("reset: busy=%0d error=%0d", io_busy, io_error);

    // Single probe: request at t, probe at t+1, ack at t+3, done at t+5
    next_cycle();  // t
    req(1'b1, 2'd1, 33'h0_0000_1040, 1'b1, 1'b1);
    io_probe_ready = 1'b1;
    sample();
    chk("single_req_ready", 64'(io_request_ready), 64'd1);
    next_cycle();  // t+1
    req(1'b0, 2'd1, 33'h0, 1'b0, 1'b0);
    sample();
    chk_probe("single", 33'h1040, 2'd2);
    next_cycle();  // t+2
    sample();
    chk("single_wait_probe_valid", 64'(io_probe_valid), 64'd0);
    chk("single_wait_busy", 64'(io_busy), 64'd1);
    next_cycle();  // t+3
    ack(1'b1, 33'h1040);
    sample();
    next_cycle();  // t+4
    ack(1'b0, 33'h0);
    sample();
    chk("single_t4_done_valid", 64'(io_done_valid), 64'd0);
    chk("single_t4_ready_m1", 64'(io_request_ready), 64'd0);
    next_cycle();  // t+5
    sample();
    chk_done("single", 2'd1);
    chk("single_t5_ready_m1", 64'(io_request_ready), 64'd1);
    chk("single_t5_busy", 64'(io_busy), 64'd0);
    chk("single_error", 64'(io_error), 64'd0);

    // Skip: allocOH=0 at t, done at t+2, never a probe
    next_cycle();  // t
    req(1'b1, 2'd2, 33'h2000, 1'b0, 1'b1);
    sample();
    chk("skip_no_done_yet", 64'(io_done_valid), 64'd0);
    next_cycle();  // t+1
    req(1'b0, 2'd0, 33'h0, 1'b0, 1'b0);
    sample();
    chk("skip_t1_probe_valid", 64'(io_probe_valid), 64'd0);
    chk("skip_t1_done_valid", 64'(io_done_valid), 64'd0);
    chk("skip_t1_busy", 64'(io_busy), 64'd1);
    next_cycle();  // t+2
    sample();
    chk_done("skip", 2'd2);
    chk("skip_t2_probe_valid", 64'(io_probe_valid), 64'd0);
    next_cycle();  // t+3
    sample();
    chk("skip_t3_done_valid", 64'(io_done_valid), 64'd0);
    chk("skip_t3_busy", 64'(io_busy), 64'd0);

    // Backpressure and fairness: four toB probes, B channel stalled for five cycles
    io_probe_ready = 1'b0;
    next_cycle();  // a
    req(1'b1, 2'd0, 33'h100, 1'b1, 1'b0);
    sample();
    chk("bp_a_probe_valid", 64'(io_probe_valid), 64'd0);
    next_cycle();  // a+1
    req(1'b1, 2'd1, 33'h140, 1'b1, 1'b0);
    sample();
    chk_probe("bp_stall1", 33'h100, 2'd1);
    next_cycle();  // a+2
    req(1'b1, 2'd2, 33'h180, 1'b1, 1'b0);
    sample();
    chk_probe("bp_stall2", 33'h100, 2'd1);
    next_cycle();  // a+3
    req(1'b1, 2'd3, 33'h1C0, 1'b1, 1'b0);
    sample();
    chk_probe("bp_stall3", 33'h100, 2'd1);
    next_cycle();  // a+4
    req(1'b0, 2'd0, 33'h0, 1'b0, 1'b0);
    sample();
    chk_probe("bp_stall4", 33'h100, 2'd1);
    next_cycle();  // a+5
    sample();
    chk_probe("bp_stall5", 33'h100, 2'd1);
    next_cycle();  // a+6
    io_probe_ready = 1'b1;
    sample();
    chk_probe("bp_order0", 33'h100, 2'd1);
    next_cycle();  // a+7
    sample();
    chk_probe("bp_order1", 33'h140, 2'd1);
    next_cycle();  // a+8: mshr0 has been in WAIT since a+7
    ack(1'b1, 33'h100);
    sample();
    chk_probe("bp_order2", 33'h180, 2'd1);
    next_cycle();  // a+9
    ack(1'b1, 33'h140);
    sample();
    chk_probe("bp_order3", 33'h1C0, 2'd1);
    next_cycle();  // a+10
    ack(1'b1, 33'h180);
    sample();
    chk("bp_drained_probe_valid", 64'(io_probe_valid), 64'd0);
    chk_done("coll_m0_first", 2'd0);

    // mshr0 freed at a+10. In a+11 an allocOH=0 request on mshr0 and the ack
    // for mshr3 arrive together, so both entries are DONE in a+12 and complete
    // in index order.
    next_cycle();  // a+11
    req(1'b1, 2'd0, 33'h200, 1'b0, 1'b0);
    ack(1'b1, 33'h1C0);
    sample();
    chk("coll_req_ready_m0", 64'(io_request_ready), 64'd1);
    chk_done("coll_m1", 2'd1);
    next_cycle();  // a+12
    req(1'b0, 2'd0, 33'h0, 1'b0, 1'b0);
    ack(1'b0, 33'h0);
    sample();
    chk_done("coll_m2", 2'd2);
    next_cycle();  // a+13
    sample();
    chk_done("coll_m0_second", 2'd0);
    next_cycle();  // a+14
    sample();
    chk_done("coll_m3", 2'd3);
    next_cycle();  // a+15
    sample();
    chk("coll_end_done_valid", 64'(io_done_valid), 64'd0);
    chk("coll_end_busy", 64'(io_busy), 64'd0);
    chk("coll_end_error", 64'(io_error), 64'd0);

`ifdef PROBE_TRACKER_TIMEOUT_EN
    // Timeout: no ack, so the probe is sent again 5 cycles after WAIT is entered.
    next_cycle();  // x
    req(1'b1, 2'd1, 33'h3000, 1'b1, 1'b1);
    sample();
    next_cycle();  // x+1
    req(1'b0, 2'd0, 33'h0, 1'b0, 1'b0);
    sample();
    chk_probe("to_first", 33'h3000, 2'd2);
    for (int c = 2; c <= 6; c++) begin
      next_cycle();  // x+2 .. x+6
      sample();
      chk("to_wait_probe_valid", 64'(io_probe_valid), 64'd0);
      chk("to_wait_error", 64'(io_error), 64'd0);
    end
    next_cycle();  // x+7
    sample();
    chk_probe("to_reissue", 33'h3000, 2'd2);
    chk("to_error", 64'(io_error), 64'd1);
    next_cycle();  // x+8
    ack(1'b1, 33'h3000);
    sample();
    next_cycle();  // x+9
    ack(1'b0, 33'h0);
    sample();
    next_cycle();  // x+10
    sample();
    chk_done("to_done", 2'd1);
    exp_err_pre = 1'b1;
`else
    exp_err_pre = 1'b0;
`endif

    // Unmatched ack sets the sticky error
    next_cycle();  // e
    ack(1'b1, 33'h9999);
    sample();
    chk("err_before", 64'(io_error), 64'(exp_err_pre));
    next_cycle();  // e+1
    ack(1'b0, 33'h0);
    sample();
    chk("err_set", 64'(io_error), 64'd1);
    chk("err_no_done", 64'(io_done_valid), 64'd0);
    next_cycle();
    next_cycle();  // e+3
    sample();
    chk("err_sticky", 64'(io_error), 64'd1);
    chk("err_busy", 64'(io_busy), 64'd0);
    $display("error: io_error=%0d", io_error);

    // Reset clears the sticky error
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    sample();
    chk("rst2_error", 64'(io_error), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
